// File: rtl/register_file_scoreboard.sv
// Register file with per-register pending-write scoreboard.
// Optional write-through bypass: define RF_BYPASS_EN.
module register_file_scoreboard #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] write_index_rf,
  input  logic [DATA_W-1:0] write_data_rf,
  input  logic              write_en_rf,
  input  logic [ADDR_W-1:0] read_index_a,
  input  logic              read_en_a,
  input  logic [ADDR_W-1:0] read_index_b,
  input  logic              read_en_b,
  output logic [DATA_W-1:0] read_data_a,
  output logic [DATA_W-1:0] read_data_b,
  input  logic              issue_en,
  input  logic              issue_dest_en,
  input  logic [ADDR_W-1:0] issue_dest_index,
  output logic              stall,
  output logic              issue_ack
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [CNT_W-1:0]  cnt  [NUM_REGS];

  logic              wb_live;
  logic              hazard_a;
  logic              hazard_b;
  logic              full;
  logic [CNT_W-1:0]  eff_a;
  logic [CNT_W-1:0]  eff_b;

  assign wb_live = write_en_rf && (write_index_rf != '0);

  // Writeback port; R0 never stored so it reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wb_live) begin
      regs[write_index_rf] <= write_data_rf;
    end
  end

  // Pending-write counters: issue increments, retire decrements,
  // retire on an empty counter holds at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        logic inc;
        logic dec;
        inc = issue_ack && issue_dest_en &&
              (issue_dest_index == ADDR_W'(i));
        dec = write_en_rf &&
              (write_index_rf == ADDR_W'(i));
        if (inc && !dec)
          cnt[i] <= cnt[i] + CNT_W'(1);
        else if (dec && !inc && cnt[i] != '0)
          cnt[i] <= cnt[i] - CNT_W'(1);
`ifdef SIM
        if (dec && !inc && cnt[i] == '0)
          $error("retire of R%0d with no pending write", i);
`endif
      end
    end
  end

  // Read ports, with optional same-cycle write-through.
  always_comb begin
    read_data_a = regs[read_index_a];
    read_data_b = regs[read_index_b];
`ifdef RF_BYPASS_EN
    if (wb_live && write_index_rf == read_index_a)
      read_data_a = write_data_rf;
    if (wb_live && write_index_rf == read_index_b)
      read_data_b = write_data_rf;
`endif
  end

  // Effective pending count seen by the hazard check.
  always_comb begin
    eff_a = cnt[read_index_a];
    eff_b = cnt[read_index_b];
`ifdef RF_BYPASS_EN
    if (write_en_rf && write_index_rf == read_index_a &&
        eff_a != '0)
      eff_a = eff_a - CNT_W'(1);
    if (write_en_rf && write_index_rf == read_index_b &&
        eff_b != '0)
      eff_b = eff_b - CNT_W'(1);
`endif
  end

  // Hazard, overflow and issue handshake.
  always_comb begin
    hazard_a  = read_en_a && (read_index_a != '0) &&
                (eff_a != '0);
    hazard_b  = read_en_b && (read_index_b != '0) &&
                (eff_b != '0);
    full      = issue_dest_en && (issue_dest_index != '0) &&
                (cnt[issue_dest_index] == CNT_MAX);
    stall     = issue_en && (hazard_a || hazard_b || full);
    issue_ack = issue_en && !stall;
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Bench for register_file_scoreboard.
// Scoreboard queue of expected outputs, popped each cycle.
module tb_register_file_scoreboard;

  logic        clk;
  logic        rst_n;
  logic [4:0]  write_index_rf;
  logic [15:0] write_data_rf;
  logic        write_en_rf;
  logic [4:0]  read_index_a;
  logic        read_en_a;
  logic [4:0]  read_index_b;
  logic        read_en_b;
  logic [15:0] read_data_a;
  logic [15:0] read_data_b;
  logic        issue_en;
  logic        issue_dest_en;
  logic [4:0]  issue_dest_index;
  logic        stall;
  logic        issue_ack;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  localparam int S_A = 0;
  localparam int S_B = 1;
  localparam int S_STALL = 2;
  localparam int S_ACK = 3;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  register_file_scoreboard dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .write_index_rf   (write_index_rf),
    .write_data_rf    (write_data_rf),
    .write_en_rf      (write_en_rf),
    .read_index_a     (read_index_a),
    .read_en_a        (read_en_a),
    .read_index_b     (read_index_b),
    .read_en_b        (read_en_b),
    .read_data_a      (read_data_a),
    .read_data_b      (read_data_b),
    .issue_en         (issue_en),
    .issue_dest_en    (issue_dest_en),
    .issue_dest_index (issue_dest_index),
    .stall            (stall),
    .issue_ack        (issue_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, expv);
    end
  endtask

  task automatic want(input int sel,
                      input logic [31:0] v,
                      input string tag);
    exp_t e;
    e.sel = sel;
    e.val = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    exp_t e;
    logic [31:0] obs;
    #3;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.sel)
        S_A:     obs = {16'h0, read_data_a};
        S_B:     obs = {16'h0, read_data_b};
        S_STALL: obs = {31'h0, stall};
        default: obs = {31'h0, issue_ack};
      endcase
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic idle();
    write_index_rf   = '0;
    write_data_rf    = '0;
    write_en_rf      = 1'b0;
    read_index_a     = '0;
    read_en_a        = 1'b0;
    read_index_b     = '0;
    read_en_b        = 1'b0;
    issue_en         = 1'b0;
    issue_dest_en    = 1'b0;
    issue_dest_index = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue_dest(input logic [4:0] d,
                            input string tag);
    issue_en = 1'b1;
    issue_dest_en = 1'b1;
    issue_dest_index = d;
    want(S_ACK, 1, tag);
    settle();
    tick();
  endtask

  task automatic retire(input logic [4:0] d,
                        input logic [15:0] v);
    write_en_rf = 1'b1;
    write_index_rf = d;
    write_data_rf = v;
    tick();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    read_index_a = 5'd5;
    read_index_b = 5'd31;
    want(S_A, 0, "rst_a");
    want(S_B, 0, "rst_b");
    want(S_STALL, 0, "rst_stall");
    want(S_ACK, 0, "rst_ack");
    settle();
    #20;
    rst_n = 1'b1;
    tick();

    // Write / read, R0 hardwired
    issue_dest(5'd5, "iss_r5");
    retire(5'd5, 16'hBEEF);
    read_index_a = 5'd5;
    read_index_b = 5'd0;
    want(S_A, 32'hBEEF, "rd_r5");
    want(S_B, 0, "rd_r0");
    settle();
    tick();
    retire(5'd0, 16'h1234);
    read_index_a = 5'd0;
    read_index_b = 5'd5;
    want(S_A, 0, "r0_after_wr");
    want(S_B, 32'hBEEF, "r5_on_b");
    settle();
    tick();

    // RAW on R3
    issue_dest(5'd3, "iss_r3");
    for (int k = 0; k < 2; k++) begin
      issue_en = 1'b1;
      read_en_a = 1'b1;
      read_index_a = 5'd3;
      want(S_STALL, 1, "raw_stall");
      want(S_ACK, 0, "raw_noack");
      settle();
      tick();
    end
    issue_en = 1'b1;
    read_en_a = 1'b1;
    read_index_a = 5'd3;
    write_en_rf = 1'b1;
    write_index_rf = 5'd3;
    write_data_rf = 16'h00AA;
    want(S_STALL, BYP ? 0 : 1, "raw_retire_stall");
    want(S_A, BYP ? 32'h00AA : 32'h0, "raw_retire_data");
    settle();
    tick();
    issue_en = 1'b1;
    read_en_a = 1'b1;
    read_index_a = 5'd3;
    want(S_STALL, 0, "raw_after_stall");
    want(S_A, 32'h00AA, "raw_after_data");
    settle();
    tick();

    // Overflow on R7
    for (int k = 0; k < 3; k++)
      issue_dest(5'd7, "iss_r7");
    issue_en = 1'b1;
    issue_dest_en = 1'b1;
    issue_dest_index = 5'd7;
    want(S_STALL, 1, "full_stall");
    settle();
    write_en_rf = 1'b1;
    write_index_rf = 5'd7;
    write_data_rf = 16'h0707;
    want(S_STALL, 1, "full_retire_stall");
    want(S_ACK, 0, "full_retire_noack");
    settle();
    tick();
    issue_dest(5'd7, "full_after_ack");
    for (int k = 0; k < 3; k++)
      retire(5'd7, 16'h0707);
    issue_en = 1'b1;
    read_en_b = 1'b1;
    read_index_b = 5'd7;
    want(S_STALL, 0, "r7_drained");
    want(S_B, 32'h0707, "r7_data");
    settle();
    tick();

    // Simultaneous issue and retire on R9
    issue_dest(5'd9, "iss_r9");
    issue_en = 1'b1;
    issue_dest_en = 1'b1;
    issue_dest_index = 5'd9;
    write_en_rf = 1'b1;
    write_index_rf = 5'd9;
    write_data_rf = 16'h0999;
    want(S_ACK, 1, "sim_ack");
    settle();
    tick();
    issue_en = 1'b1;
    read_en_b = 1'b1;
    read_index_b = 5'd9;
    want(S_STALL, 1, "sim_cnt_one");
    settle();
    write_en_rf = 1'b1;
    write_index_rf = 5'd9;
    write_data_rf = 16'h0900;
    want(S_STALL, BYP ? 0 : 1, "sim_retire_stall");
    settle();
    tick();
    issue_en = 1'b1;
    read_en_b = 1'b1;
    read_index_b = 5'd9;
    want(S_STALL, 0, "sim_cnt_zero");
    want(S_B, 32'h0900, "sim_data");
    settle();
    tick();

    // Spurious retire of R12
    retire(5'd12, 16'hC0DE);
    issue_en = 1'b1;
    read_en_a = 1'b1;
    read_index_a = 5'd12;
    want(S_STALL, 0, "spur_no_hazard");
    want(S_A, 32'hC0DE, "spur_data");
    settle();
    tick();
    for (int k = 0; k < 3; k++)
      issue_dest(5'd12, "spur_cnt_iss");
    issue_en = 1'b1;
    issue_dest_en = 1'b1;
    issue_dest_index = 5'd12;
    want(S_STALL, 1, "spur_full");
    settle();
    tick();

    // Mid-run reset with R20 and R12 in flight
    issue_dest(5'd20, "iss_r20");
    #2;
    rst_n = 1'b0;
    issue_en = 1'b1;
    read_en_a = 1'b1;
    read_en_b = 1'b1;
    for (int i = 0; i < 32; i++) begin
      read_index_a = 5'(i);
      read_index_b = 5'(31 - i);
      want(S_A, 0, "mrst_a");
      want(S_B, 0, "mrst_b");
      want(S_STALL, 0, "mrst_stall");
      settle();
    end
    rst_n = 1'b1;
    tick();
    issue_en = 1'b1;
    read_en_a = 1'b1;
    read_index_a = 5'd20;
    read_en_b = 1'b1;
    read_index_b = 5'd12;
    issue_dest_en = 1'b1;
    issue_dest_index = 5'd12;
    want(S_STALL, 0, "post_rst_stall");
    want(S_ACK, 1, "post_rst_ack");
    want(S_B, 0, "post_rst_r12");
    settle();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
